// File: rtl/mod_mul_pkg.sv
// mod_mul_pkg: shared states, half-width helper and width check for mod_mul blocks
`ifndef MOD_MUL_PKG_SV
`define MOD_MUL_PKG_SV
`define MOD_MUL_WIDTH_CHECK(w) if ((((w) % 2) != 0) || ((w) < 4)) begin : g_width_bad $fatal(1, "operand width must be even and >= 4"); end
package mod_mul_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_BD   = 3'd1,
    S_AC   = 3'd2,
    S_MID  = 3'd3,
    S_COMB = 3'd4,
    DONE   = 3'd5
  } state_t;
  function automatic int ko_half(input int w);
    return w / 2;
  endfunction
endpackage
`endif

// File: rtl/mul_ko_param_if.sv
// mul_ko_param_if: operand/result valid-ready bus of the Karatsuba multiplier
interface mul_ko_param_if #(parameter int W = 256) ();
  logic           in_vld;
  logic           in_rdy;
  logic [W-1:0]   mul_a_i;
  logic [W-1:0]   mul_b_i;
  logic           out_vld;
  logic           out_rdy;
  logic [2*W-1:0] mul_r_o;
  logic           busy_o;
  modport master (output in_vld, mul_a_i, mul_b_i, out_rdy, input in_rdy, out_vld, mul_r_o, busy_o);
  modport slave  (input in_vld, mul_a_i, mul_b_i, out_rdy, output in_rdy, out_vld, mul_r_o, busy_o);
endinterface

// File: rtl/mul_uns_comb.sv
// mul_uns_comb: combinational NxN->2N unsigned multiplier (behavioural stand-in for the DSP macro)
module mul_uns_comb #(parameter int N = 8) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
endmodule

// File: rtl/mul_ko_param.sv
// mul_ko_param: W x W -> 2W unsigned Karatsuba multiplier, three passes through one (H+1)-bit multiplier
module mul_ko_param
  import mod_mul_pkg::*;
#(
  parameter int W = 256
) (
  input logic           clk,
  input logic           rst_n,
  mul_ko_param_if.slave bus
);
  localparam int H = ko_half(W);
  localparam int X = 2 * W + 2;
  `MOD_MUL_WIDTH_CHECK(W)
  state_t         st, nx;
  logic [H-1:0]   a_q, b_q, c_q, d_q;
  logic [H:0]     apb, cpd, x, y;
  logic [2*H+1:0] prod, p1;
  logic [2*H-1:0] p0, p2;
  logic [2*W-1:0] r;
  logic [X-1:0]   sum;
  logic           acc, unused_hi;
  assign acc         = bus.in_vld & bus.in_rdy;
  assign bus.in_rdy  = (st == IDLE) | ((st == DONE) & bus.out_rdy);
  assign bus.out_vld = st == DONE;
  assign bus.busy_o  = st != IDLE;
  assign bus.mul_r_o = r;
  always_comb begin
    nx = st;
    case (st)
      IDLE:    nx = acc ? S_BD : IDLE;
      S_BD:    nx = S_AC;
      S_AC:    nx = S_MID;
      S_MID:   nx = S_COMB;
      S_COMB:  nx = DONE;
      DONE:    nx = acc ? S_BD : bus.out_rdy ? IDLE : DONE;
      default: nx = IDLE;
    endcase
  end
  // sub-multiplier is parked at zero outside the three product states
  always_comb begin
    x = st == S_BD ? {1'b0, b_q} : st == S_AC ? {1'b0, a_q} : st == S_MID ? apb : '0;
    y = st == S_BD ? {1'b0, d_q} : st == S_AC ? {1'b0, c_q} : st == S_MID ? cpd : '0;
  end
  mul_uns_comb #(.N(H + 1)) u_mul (.a(x), .b(y), .p(prod));
  // wide enough for every intermediate; the top two bits end up zero
  always_comb begin
    sum = ({{(X-2*H){1'b0}}, p2} << W)
        + (({{(X-2*H-2){1'b0}}, p1} - {{(X-2*H){1'b0}}, p0} - {{(X-2*H){1'b0}}, p2}) << H)
        + {{(X-2*H){1'b0}}, p0};
  end
  assign unused_hi = ^sum[X-1:2*W];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      apb <= '0;
      cpd <= '0;
      p0  <= '0;
      p1  <= '0;
      p2  <= '0;
      r   <= '0;
    end else begin
      st <= nx;
      if (acc) begin
        {a_q, b_q} <= bus.mul_a_i;
        {c_q, d_q} <= bus.mul_b_i;
        apb        <= {1'b0, bus.mul_a_i[W-1:H]} + {1'b0, bus.mul_a_i[H-1:0]};
        cpd        <= {1'b0, bus.mul_b_i[W-1:H]} + {1'b0, bus.mul_b_i[H-1:0]};
      end
      if (st == S_BD) p0 <= prod[2*H-1:0];
      if (st == S_AC) p2 <= prod[2*H-1:0];
      if (st == S_MID) p1 <= prod;
      if (st == S_COMB) r <= sum[2*W-1:0];
    end
  end
endmodule

// File: tb/tb_mul_ko_param.sv
// tb_mul_ko_param: W=8/16/256 instances in lockstep, checked against plain-multiply reference
module tb_mul_ko_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  mul_ko_param_if #(.W(8))   b8 ();
  mul_ko_param_if #(.W(16))  b16 ();
  mul_ko_param_if #(.W(256)) b256 ();
  mul_ko_param #(.W(8))   u8   (.clk(clk), .rst_n(rst_n), .bus(b8));
  mul_ko_param #(.W(16))  u16  (.clk(clk), .rst_n(rst_n), .bus(b16));
  mul_ko_param #(.W(256)) u256 (.clk(clk), .rst_n(rst_n), .bus(b256));
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [511:0] ref_mul(input int w, input logic [255:0] a, input logic [255:0] b);
    logic [511:0] m;
    m = (512'd1 << w) - 512'd1;
    return ({256'd0, a} & m) * ({256'd0, b} & m);
  endfunction
  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [255:0] a, input logic [255:0] b);
    b8.in_vld = v;   b8.mul_a_i = a[7:0];    b8.mul_b_i = b[7:0];
    b16.in_vld = v;  b16.mul_a_i = a[15:0];  b16.mul_b_i = b[15:0];
    b256.in_vld = v; b256.mul_a_i = a;       b256.mul_b_i = b;
  endtask
  task automatic set_rdy(input logic r);
    b8.out_rdy = r;
    b16.out_rdy = r;
    b256.out_rdy = r;
  endtask
  function automatic logic [2:0] vlds();
    return {b8.out_vld, b16.out_vld, b256.out_vld};
  endfunction
  function automatic logic [2:0] rdys();
    return {b8.in_rdy, b16.in_rdy, b256.in_rdy};
  endfunction
  function automatic logic [2:0] busys();
    return {b8.busy_o, b16.busy_o, b256.busy_o};
  endfunction
  task automatic check_res(input string tag, input logic [255:0] a, input logic [255:0] b);
    check({tag, "_w8"}, 512'(b8.mul_r_o), ref_mul(8, a, b));
    check({tag, "_w16"}, 512'(b16.mul_r_o), ref_mul(16, a, b));
    check({tag, "_w256"}, 512'(b256.mul_r_o), ref_mul(256, a, b));
  endtask
  task automatic do_op(input logic [255:0] a, input logic [255:0] b, input bit hold);
    int lat;
    bit bad;
    logic [511:0] r8, r16, r256;
    set_rdy(!hold);
    drive(1'b1, a, b);
    check("rdy_idle", 512'(rdys()), 512'(3'b111));
    tick();
    drive(1'b0, ~a, ~b);
    lat = 0;
    bad = 0;
    while (b256.out_vld !== 1'b1 && lat < 20) begin
      if (rdys() !== 3'b000 || busys() !== 3'b111) bad = 1;
      tick();
      lat++;
    end
    check("latency", 512'(lat), 512'(4));
    check("rdy_low_busy", 512'(bad), 512'(0));
    check("vld_all", 512'(vlds()), 512'(3'b111));
    check_res("res", a, b);
    if (hold) begin
      r8 = 512'(b8.mul_r_o);
      r16 = 512'(b16.mul_r_o);
      r256 = 512'(b256.mul_r_o);
      bad = 0;
      repeat (10) begin
        drive(1'b1, rnd256(), rnd256());
        tick();
        if (512'(b8.mul_r_o) !== r8 || 512'(b16.mul_r_o) !== r16 || 512'(b256.mul_r_o) !== r256) bad = 1;
        if (vlds() !== 3'b111 || rdys() !== 3'b000) bad = 1;
      end
      check("hold_stable", 512'(bad), 512'(0));
      drive(1'b0, 256'd0, 256'd0);
      set_rdy(1'b1);
      #1;
      check("rdy_on_accept", 512'(rdys()), 512'(3'b111));
    end
    tick();
    check("vld_drop", 512'(vlds()), 512'(3'b000));
    check("busy_idle", 512'(busys()), 512'(3'b000));
    check_res("keep", a, b);
    tick();
    check("vld_once", 512'(vlds()), 512'(3'b000));
  endtask
  task automatic b2b();
    logic [255:0] pa [3];
    logic [255:0] pb [3];
    int k, nres, last, cyc;
    bit acc, busy_bad;
    for (int i = 0; i < 3; i++) begin
      pa[i] = rnd256();
      pb[i] = rnd256();
    end
    set_rdy(1'b1);
    drive(1'b1, pa[0], pb[0]);
    k = 0;
    nres = 0;
    last = 0;
    cyc = 0;
    busy_bad = 0;
    while (nres < 3 && cyc < 40) begin
      acc = b256.in_vld & b256.in_rdy;
      tick();
      cyc++;
      if (acc) begin
        k++;
        if (k < 3) drive(1'b1, pa[k], pb[k]);
        else drive(1'b0, 256'd0, 256'd0);
      end
      if (busys() !== 3'b111) busy_bad = 1;
      if (b256.out_vld === 1'b1) begin
        check_res("b2b", pa[nres], pb[nres]);
        if (nres > 0) check("b2b_gap", 512'(cyc - last), 512'(5));
        last = cyc;
        nres++;
      end
    end
    check("b2b_count", 512'(nres), 512'(3));
    check("b2b_no_idle", 512'(busy_bad), 512'(0));
    tick();
    check("b2b_end_idle", 512'(busys()), 512'(3'b000));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [255:0] t;
    bit bad;
    drive(1'b0, 256'd0, 256'd0);
    set_rdy(1'b1);
    tick();
    check("rst_vld", 512'(vlds()), 512'(3'b000));
    check("rst_r256", 512'(b256.mul_r_o), 512'd0);
    check("rst_busy", 512'(busys()), 512'(3'b000));
    rst_n = 1'b1;
    tick();
    check("rst_rdy", 512'(rdys()), 512'(3'b111));
    do_op({256{1'b1}}, {256{1'b1}}, 0);
    check("ff_w8", 512'(b8.mul_r_o), 512'h FE01);
    check("ones_w256", 512'(b256.mul_r_o), (512'd1 << 512) - (512'd1 << 257) + 512'd1);
    do_op(256'd0, rnd256(), 0);
    t = rnd256();
    t[31:0] = 32'hDEADBEEF;
    do_op(256'd1, t, 0);
    check("one_w256", 512'(b256.mul_r_o), {256'd0, t});
    do_op(256'h1234, 256'h5678, 1);
    check("bp_w16", 512'(b16.mul_r_o), 512'h0626_0060);
    b2b();
    for (int i = 0; i < 6; i++) do_op(rnd256(), rnd256(), i[0]);
    drive(1'b1, 256'h80, 256'h80);
    tick();
    drive(1'b0, 256'd0, 256'd0);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 512'(vlds()), 512'(3'b000));
    check("mid_rst_r8", 512'(b8.mul_r_o), 512'd0);
    check("mid_rst_r256", 512'(b256.mul_r_o), 512'd0);
    check("mid_rst_rdy", 512'(rdys()), 512'(3'b111));
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      tick();
      if (vlds() !== 3'b000 || busys() !== 3'b000) bad = 1;
    end
    check("mid_rst_quiet", 512'(bad), 512'(0));
    do_op(256'h03, 256'h05, 0);
    check("post_rst_w8", 512'(b8.mul_r_o), 512'h000F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_ko_param.md
Name: mul_ko_param

Overview:
- Parametrised unsigned W×W → 2W Karatsuba multiplier built around one reused (H+1)-bit combinational sub-multiplier, where H = W/2.
- Computes {A,B}×{C,D} in three sub-products: B·D, A·C, (A+B)(C+D).
- Full valid/ready handshake on both sides; the result holds under backpressure.
- Sits in the SM2 modular-multiply path as the generic replacement for the fixed 128b multiplier. It is instanced at W=256 for the field multiply and W=128 for partial products.

Parameters:
- W, 256, operand width; must be even and ≥4; violation is fatal at elaboration.
- H, W/2, derived half width; not to be overridden.

Ports:
- clk  in  1  clock; all flops rise-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_vld  in  1  operand valid.
- in_rdy  out  1  block can accept operands.
- mul_a_i  in  W  operand {A,B}, A = upper H bits.
- mul_b_i  in  W  operand {C,D}, C = upper H bits.
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream accepts result.
- mul_r_o  out  2W  product a·b.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: out_vld=0, mul_r_o=0, busy_o=0, state=IDLE. in_rdy=1 once reset deasserts, because it decodes IDLE.
- Reset mid-operation discards everything. No out_vld is produced for the in-flight operation.
- FSM states are IDLE, S_BD, S_AC, S_MID, S_COMB, DONE.
- Accept occurs when in_vld & in_rdy at edge k:
  - latch A, B, C, D;
  - register ApB = A+B and CpD = C+D, each H+1 bits, no truncation;
  - next state S_BD.
- S_BD: sub-multiplier inputs are zero-extended B, D. P0 (2H bits) is registered at edge k+1. Next state S_AC.
- S_AC: inputs A, C. P2 is registered at edge k+2. Next state S_MID.
- S_MID: inputs ApB, CpD at full H+1 width. No correction term is used. P1 (2H+2 bits) is registered at edge k+3. Next state S_COMB.
- S_COMB: the result is registered at edge k+4 as R = (P2<<W) + ((P1−P0−P2)<<H) + P0.
  - Evaluate in 2W+2 bits, then truncate to 2W; the upper bits are provably zero.
  - P1−P0−P2 is never negative.
  - Set out_vld=1. Next state DONE.
- Latency: out_vld is high from edge k+4, i.e. 4 cycles after accept.
- DONE:
  - mul_r_o and out_vld stay stable while out_rdy=0, for unbounded duration.
  - On out_rdy=1 at an edge, out_vld drops to 0.
  - If in_vld is also high at that edge, new operands are accepted (next S_BD). Otherwise next state is IDLE.
- in_rdy = (state==IDLE) | (state==DONE & out_rdy). It is combinational from out_rdy only; there is no in_vld→in_rdy path.
- Throughput: back-to-back issue gives one result per 5 cycles.
- Operand inputs are sampled only on accept; changes at any other time are ignored.
- mul_r_o keeps the last result after it has been accepted. It is updated only in S_COMB.
- The sub-multiplier inputs are zero in IDLE and DONE, to limit toggling.
- The critical path is one (H+1)-bit multiply plus register, or one 2W+2-bit three-operand add; the two are never in series.

Decomposition:
- Shared package mod_mul_pkg holds:
  - state encoding constants (IDLE..DONE, 3-bit);
  - a function ko_half(W) returning W/2;
  - a width-check macro reused by other mod_mul blocks.
- One sub-module: mul_uns_comb #(N), a combinational N×N→2N unsigned multiplier, instanced once with N=H+1. It wraps the vendor DSP IP or falls back to a behavioural `*`.
- The FSM, datapath registers and combine adder stay in mul_ko_param.

Test Plan:
- W=8, a=0xFF, b=0xFF, out_rdy=1 → out_vld exactly 4 cycles after accept, mul_r_o=0xFE01. in_rdy is low for cycles 1–4 after accept.
- W=256, a=b=2^256−1 → mul_r_o = 2^512 − 2^257 + 1. This exercises ApB and CpD carry (bit H set) in S_MID.
- W=256, a=0, b=random; then a=1, b=0x…DEADBEEF → products 0 and b. out_vld pulses once per accepted operation.
- Backpressure, W=16, a=0x1234, b=0x5678: hold out_rdy=0 for 10 cycles → mul_r_o=0x06260060 stays stable and out_vld stays 1. Operands changed during the hold must not alter the result. in_rdy stays 0 until out_rdy rises.
- Back-to-back, W=16: in_vld held high with 3 operand pairs and out_rdy=1 → results at 5-cycle spacing, in order, each matching the reference model. DONE→S_BD occurs without passing through IDLE.
- Reset mid-op, W=8, a=0x80, b=0x80: assert rst_n=0 during S_AC → out_vld=0, mul_r_o=0, in_rdy=1 after release. A subsequent 0x03×0x05 returns 0x000F.
